io_bidir_multichannel_bel: RTL and testbench
============================================

Name: io_bidir_multichannel_bel

Overview:
- Parametrised successor to the single-channel bidirectional frame-config IO BEL, used in W/E IO tiles.
- Carries NUM_CH independent pad channels in one BEL.
- Per channel, ConfigBits select registered or combinational output and tristate paths, a tristate override mode, and the input mode: comb, registered, glitch-filtered or disabled.
- Sits between the tile switch matrix (I, T, O, Q) and the tile top-level pad pins (*_top).

Parameters:
- NUM_CH, 2, number of pad channels.
- FILT_LEN, 4, consecutive stable cycles required before the filtered input changes (>=1).
- CFG_PER_CH, 6, config bits per channel; fixed, not to be overridden.

Ports:
- UserCLK  in  1  fabric user clock; all state is on its rising edge.
- UserRST  in  1  synchronous active-high reset.
- I  in  NUM_CH  fabric-to-pad data from the switch matrix.
- T  in  NUM_CH  fabric tristate control; 1 = hi-Z.
- O  out  NUM_CH  pad-to-fabric data after the input-mode selection.
- Q  out  NUM_CH  registered pad input, always available.
- I_top  out  NUM_CH  pad output data.
- T_top  out  NUM_CH  pad tristate; 1 = hi-Z.
- O_top  in  NUM_CH  pad input data.
- ConfigBits  in  NUM_CH*6  static per-channel configuration; channel k uses bits [6k+5:6k].

Behaviour:
- Interface: one clock, UserCLK. Reset UserRST is synchronous and active-high. ConfigBits are quasi-static and need not be synchronised.
- Per-channel config field cfg[5:0]:
  - cfg[0] out_reg: 0 = I_top is comb from I; 1 = I_top is a flop of I (1 cycle latency).
  - cfg[1] t_reg: same choice for the tristate path, applied after the T-mode function.
  - cfg[3:2] t_mode: 00 = T; 01 = force drive (0); 10 = force hi-Z (1); 11 = ~T.
  - cfg[5:4] in_mode: 00 = O comb from pad; 01 = O = pad flop (1 cycle); 10 = O = filtered value F; 11 = O forced 0.
- Q: flop of the pad sample every cycle, independent of in_mode.
- Pad sample: O_top directly, or the synchroniser output when the optional feature is compiled in.
- Filter, per channel: stable register F plus counter C of width clog2(FILT_LEN+1).
  - sample == F: C <= 0.
  - sample != F and C == FILT_LEN-1: F <= sample, C <= 0.
  - otherwise: C <= C+1.
  - Any glitch shorter than FILT_LEN cycles leaves F unchanged and restarts the count.
  - A change held for exactly FILT_LEN cycles appears on O FILT_LEN cycles after the first differing sample.
  - FILT_LEN = 1 behaves identically to registered mode.
- Filter and Q flops run in every mode; switching into mode 10 uses the current F with no reset.
- Reset, applied at the next edge while UserRST = 1:
  - I_top flops <= 0; T_top flops <= 1 (hi-Z); Q <= 0; F <= 0; C <= 0; synchroniser flops <= 0.
  - Combinational paths are unaffected by reset.
- Reset mid-filter-count discards the count. After reset F = 0, so a pad held at 1 reaches O after FILT_LEN cycles.
- Channels are fully independent; no cross-channel state.

Optional Feature:
- Macro IO_BEL_SYNC_EN.
  - Defined: a 2-flop synchroniser on each O_top, reset to 0. It feeds Q, registered mode and the filter, adding 2 cycles to each (Q latency 3). Comb mode 00 still uses raw O_top.
  - Undefined: the pad sample is O_top directly; Q latency 1.

Decomposition:
- Package io_bel_pkg holds:
  - localparams for the cfg bit positions (OUT_REG, T_REG, T_MODE lsb, IN_MODE lsb) and CFG_PER_CH = 6;
  - enums t_mode_e {T_PASS, T_DRIVE, T_HIZ, T_INV} and in_mode_e {IN_COMB, IN_REG, IN_FILT, IN_OFF}.
- Sub-module io_bel_channel holds one channel's full datapath, filter and synchroniser. The top generates NUM_CH instances and slices ConfigBits.

Test Plan:
- Reset: UserRST = 1 for 2 cycles with all channels out_reg = 1, t_reg = 1 -> I_top = 0, T_top = 1, Q = 0, O = 0 in mode 01; release -> registered values appear 1 cycle later.
- Output modes on channel 0: cfg = 0, I toggles -> I_top follows the same cycle. cfg = 1 -> 1-cycle lag. t_mode = 10 -> T_top = 1 regardless of T. t_mode = 11, T = 0 -> T_top = 1.
- Filter, FILT_LEN = 4, mode 10, F = 0:
  - pad 1 for 3 cycles then 0 -> O stays 0, C returns to 0.
  - pad 1 for 4 cycles -> O = 1 on the 4th edge after the first sampled 1.
  - pad 1 for 4 cycles then 0 -> O stays 1.
- Reset at C = 2 with pad 1 -> F = 0, C = 0. Pad remains 1 -> O = 1 after 4 more cycles.
- NUM_CH = 4, each channel a different in_mode (00/01/10/11), same O_top stimulus -> O0 comb, O1 lagged 1, O2 filtered, O3 = 0; Q identical on all channels.
- With IO_BEL_SYNC_EN: step on O_top -> Q changes 3 cycles later, mode-01 O 3 cycles later, mode-00 O immediately.

Source files
------------

// File: rtl/io_bidir_multichannel_bel_pkg.sv
// rtl/io_bidir_multichannel_bel_pkg.sv - shared config-field layout and mode enums for the multichannel IO BEL
package io_bel_pkg;

   // Width of one channel's config field in ConfigBits; fixed by the tile config frame layout.
   localparam int CFG_PER_CH  = 6;

   // Bit positions inside a channel's config field.
   localparam int OUT_REG     = 0;
   localparam int T_REG       = 1;
   localparam int T_MODE_LSB  = 2;
   localparam int IN_MODE_LSB = 4;

   // Tristate function applied to T before the optional tristate flop.
   typedef enum logic [1:0] {
      T_PASS  = 2'b00,
      T_DRIVE = 2'b01,
      T_HIZ   = 2'b10,
      T_INV   = 2'b11
   } t_mode_e;

   // Source of O towards the fabric.
   typedef enum logic [1:0] {
      IN_COMB = 2'b00,
      IN_REG  = 2'b01,
      IN_FILT = 2'b10,
      IN_OFF  = 2'b11
   } in_mode_e;

endpackage

// File: rtl/io_bidir_multichannel_bel_if.sv
// rtl/io_bidir_multichannel_bel_if.sv - fabric/pad signal bundle of W pad channels
interface io_bel_if #(
   parameter int W = 1
);
   // Fabric side: i/t go towards the pad, o/q come back from it.
   logic [W-1:0] i;
   logic [W-1:0] t;
   logic [W-1:0] o;
   logic [W-1:0] q;
   // Pad side.
   logic [W-1:0] i_top;
   logic [W-1:0] t_top;
   logic [W-1:0] o_top;

   // master: whoever drives the fabric inputs and the pad input (switch matrix / pad model).
   modport master (
      output i, t, o_top,
      input  o, q, i_top, t_top
   );

   // slave: the BEL channel.
   modport slave (
      input  i, t, o_top,
      output o, q, i_top, t_top
   );
endinterface

// File: rtl/io_bidir_multichannel_bel_channel.sv
// rtl/io_bidir_multichannel_bel_channel.sv - one pad channel: output/tristate paths, input select, glitch filter; optional IO_BEL_SYNC_EN synchroniser
module io_bel_channel
   import io_bel_pkg::*;
#(
   parameter int FILT_LEN = 4
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [CFG_PER_CH-1:0] cfg_i,
   io_bel_if.slave               pad
);

   // Counter must hold values up to FILT_LEN-1; clog2(FILT_LEN+1) keeps FILT_LEN=1 at one bit.
   localparam int CNT_W = $clog2(FILT_LEN + 1);

   t_mode_e    t_mode;
   in_mode_e   in_mode;

   logic       sample;        // pad value seen by Q, registered mode and the filter
   logic       t_fn;          // tristate after the T-mode function, before the optional flop
   logic       o_sel;

   logic       i_top_q;
   logic       t_top_q;
   logic       q_q;
   logic       f_q, f_d;
   logic [CNT_W-1:0] c_q, c_d;

   assign t_mode  = t_mode_e'(cfg_i[T_MODE_LSB +: 2]);
   assign in_mode = in_mode_e'(cfg_i[IN_MODE_LSB +: 2]);

`ifdef IO_BEL_SYNC_EN
   logic sync1_q;
   logic sync2_q;

   // Two-flop synchroniser on the pad input; the comb input mode bypasses it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= pad.o_top;
         sync2_q <= sync1_q;
      end
   end

   assign sample = sync2_q;
`else
   assign sample = pad.o_top;
`endif

   // Tristate function selected by t_mode.
   always_comb begin
      t_fn = pad.t;
      unique case (t_mode)
         T_PASS:  t_fn = pad.t;
         T_DRIVE: t_fn = 1'b0;
         T_HIZ:   t_fn = 1'b1;
         T_INV:   t_fn = ~pad.t;
      endcase
   end

   // Output-side flops; the tristate flop resets to hi-Z so the pad never drives out of reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         i_top_q <= 1'b0;
         t_top_q <= 1'b1;
      end else begin
         i_top_q <= pad.i;
         t_top_q <= t_fn;
      end
   end

   assign pad.i_top = cfg_i[OUT_REG] ? i_top_q : pad.i;
   assign pad.t_top = cfg_i[T_REG]   ? t_top_q : t_fn;

   // Registered pad sample; runs in every mode and also serves the registered input mode.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q_q <= 1'b0;
      end else begin
         q_q <= sample;
      end
   end

   // Glitch filter next state: F only moves after FILT_LEN consecutive differing samples.
   always_comb begin
      f_d = f_q;
      c_d = c_q;
      if (sample == f_q) begin
         c_d = '0;
      end else if (c_q == CNT_W'(FILT_LEN - 1)) begin
         f_d = sample;
         c_d = '0;
      end else begin
         c_d = c_q + CNT_W'(1);
      end
   end

   // Glitch filter state; runs regardless of in_mode so switching into filtered mode uses a live F.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         f_q <= 1'b0;
         c_q <= '0;
      end else begin
         f_q <= f_d;
         c_q <= c_d;
      end
   end

   // Input-mode selection towards the fabric.
   always_comb begin
      o_sel = 1'b0;
      unique case (in_mode)
         IN_COMB: o_sel = pad.o_top;
         IN_REG:  o_sel = q_q;
         IN_FILT: o_sel = f_q;
         IN_OFF:  o_sel = 1'b0;
      endcase
   end

   assign pad.o = o_sel;
   assign pad.q = q_q;

endmodule

// File: rtl/io_bidir_multichannel_bel.sv
// rtl/io_bidir_multichannel_bel.sv - NUM_CH-channel bidirectional frame-config IO BEL top; optional IO_BEL_SYNC_EN
module io_bidir_multichannel_bel
   import io_bel_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int FILT_LEN = 4
)(
   input  logic                         UserCLK,
   input  logic                         UserRST,
   input  logic [NUM_CH-1:0]            I,
   input  logic [NUM_CH-1:0]            T,
   output logic [NUM_CH-1:0]            O,
   output logic [NUM_CH-1:0]            Q,
   output logic [NUM_CH-1:0]            I_top,
   output logic [NUM_CH-1:0]            T_top,
   input  logic [NUM_CH-1:0]            O_top,
   input  logic [NUM_CH*CFG_PER_CH-1:0] ConfigBits
);

   // One independent channel per pad; each gets its own slice of ConfigBits.
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      io_bel_if #(.W(1)) ch_if ();

      assign ch_if.i     = I[k];
      assign ch_if.t     = T[k];
      assign ch_if.o_top = O_top[k];

      assign O[k]     = ch_if.o;
      assign Q[k]     = ch_if.q;
      assign I_top[k] = ch_if.i_top;
      assign T_top[k] = ch_if.t_top;

      io_bel_channel #(
         .FILT_LEN (FILT_LEN)
      ) u_ch (
         .clk_i (UserCLK),
         .rst_i (UserRST),
         .cfg_i (ConfigBits[k*CFG_PER_CH +: CFG_PER_CH]),
         .pad   (ch_if.slave)
      );
   end

endmodule

// File: tb/tb_io_bidir_multichannel_bel.sv
// tb/tb_io_bidir_multichannel_bel.sv - randomized self-checking bench with behavioural model for io_bidir_multichannel_bel
module tb_io_bidir_multichannel_bel;

   localparam int NUM_CH   = 4;
   localparam int FILT_LEN = 4;

   logic                  UserCLK;
   logic                  UserRST;
   logic [NUM_CH*6-1:0]   cfg;
   logic                  check_en;
   int                    n_chk;
   int                    n_fail;

   io_bel_if #(.W(NUM_CH)) bus ();

   io_bidir_multichannel_bel #(
      .NUM_CH   (NUM_CH),
      .FILT_LEN (FILT_LEN)
   ) dut (
      .UserCLK    (UserCLK),
      .UserRST    (UserRST),
      .I          (bus.i),
      .T          (bus.t),
      .O          (bus.o),
      .Q          (bus.q),
      .I_top      (bus.i_top),
      .T_top      (bus.t_top),
      .O_top      (bus.o_top),
      .ConfigBits (cfg)
   );

   initial UserCLK = 1'b0;
   always #5 UserCLK = ~UserCLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge UserCLK);
      #1;
   endtask

   task automatic at_mid();
      @(negedge UserCLK);
      #1;
   endtask

   function automatic logic tfn(input logic [1:0] m, input logic t);
      case (m)
         2'd0:    return t;
         2'd1:    return 1'b0;
         2'd2:    return 1'b1;
         default: return ~t;
      endcase
   endfunction

   // Behavioural model. The filter is described as "F is the value of the most recent stretch of
   // FILT_LEN identical samples since reset (0 if none)", tracked as current run value and length.
   logic [NUM_CH-1:0] m_ireg, m_treg, m_q, m_f, m_s1, m_s2, m_runv;
   int                m_len [NUM_CH];

   always @(posedge UserCLK) begin
      logic [NUM_CH-1:0] smp;
      logic [5:0]        c;
`ifdef IO_BEL_SYNC_EN
      smp = m_s2;
`else
      smp = bus.o_top;
`endif
      if (UserRST) begin
         m_ireg = '0;
         m_treg = '1;
         m_q    = '0;
         m_f    = '0;
         m_s1   = '0;
         m_s2   = '0;
         for (int k = 0; k < NUM_CH; k++) m_len[k] = 0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            c = cfg[6*k +: 6];
            m_ireg[k] = bus.i[k];
            m_treg[k] = tfn(c[3:2], bus.t[k]);
            m_q[k]    = smp[k];
            if (m_len[k] > 0 && smp[k] == m_runv[k]) begin
               if (m_len[k] < FILT_LEN) m_len[k]++;
            end else begin
               m_runv[k] = smp[k];
               m_len[k]  = 1;
            end
            if (m_len[k] >= FILT_LEN) m_f[k] = m_runv[k];
         end
         m_s2 = m_s1;
         m_s1 = bus.o_top;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge UserCLK) begin
      logic [NUM_CH-1:0] e_it, e_tt, e_o;
      logic [5:0]        c;
      if (check_en) begin
         for (int k = 0; k < NUM_CH; k++) begin
            c = cfg[6*k +: 6];
            e_it[k] = c[0] ? m_ireg[k] : bus.i[k];
            e_tt[k] = c[1] ? m_treg[k] : tfn(c[3:2], bus.t[k]);
            case (c[5:4])
               2'd0:    e_o[k] = bus.o_top[k];
               2'd1:    e_o[k] = m_q[k];
               2'd2:    e_o[k] = m_f[k];
               default: e_o[k] = 1'b0;
            endcase
         end
         chk("cmp_i_top", 32'(bus.i_top), 32'(e_it));
         chk("cmp_t_top", 32'(bus.t_top), 32'(e_tt));
         chk("cmp_q",     32'(bus.q),     32'(m_q));
         chk("cmp_o",     32'(bus.o),     32'(e_o));
      end
   end

   initial begin
      logic v;
      check_en = 1'b0;
      n_chk    = 0;
      n_fail   = 0;

      // Reset with registered output/tristate and registered input mode on all channels.
      for (int k = 0; k < NUM_CH; k++) cfg[6*k +: 6] = 6'b010011;
      bus.i     = '1;
      bus.t     = '0;
      bus.o_top = '1;
      UserRST   = 1'b1;
      tick();
      check_en = 1'b1;
      tick();
      at_mid();
      chk("rst_i_top", 32'(bus.i_top), 32'h0);
      chk("rst_t_top", 32'(bus.t_top), 32'hF);
      chk("rst_q",     32'(bus.q),     32'h0);
      chk("rst_o",     32'(bus.o),     32'h0);
      UserRST = 1'b0;
      tick();
      at_mid();
      chk("rel_i_top", 32'(bus.i_top), 32'hF);
      chk("rel_t_top", 32'(bus.t_top), 32'h0);
`ifndef IO_BEL_SYNC_EN
      chk("rel_q", 32'(bus.q), 32'hF);
      chk("rel_o", 32'(bus.o), 32'hF);
`endif

      // Output and tristate modes on channel 0.
      cfg[0 +: 6] = 6'b000000;
      bus.i[0] = 1'b0; #1 chk("comb_i_top_0", 32'(bus.i_top[0]), 32'h0);
      bus.i[0] = 1'b1; #1 chk("comb_i_top_1", 32'(bus.i_top[0]), 32'h1);
      bus.t[0] = 1'b1; #1 chk("comb_t_top",   32'(bus.t_top[0]), 32'h1);
      tick();
      at_mid();
      cfg[0 +: 6] = 6'b000001;
      bus.i[0] = 1'b0; #1 chk("reg_i_top_hold", 32'(bus.i_top[0]), 32'h1);
      tick();
      at_mid();
      chk("reg_i_top_lag", 32'(bus.i_top[0]), 32'h0);
      cfg[0 +: 6] = 6'b001000;
      bus.t[0] = 1'b0; #1 chk("tmode_hiz",  32'(bus.t_top[0]), 32'h1);
      cfg[0 +: 6] = 6'b001100;
      bus.t[0] = 1'b0; #1 chk("tmode_inv0", 32'(bus.t_top[0]), 32'h1);
      bus.t[0] = 1'b1; #1 chk("tmode_inv1", 32'(bus.t_top[0]), 32'h0);
      tick();

`ifndef IO_BEL_SYNC_EN
      // Filter on channel 2 from F = 0.
      cfg[2*6 +: 6] = 6'b100000;
      UserRST = 1'b1; bus.o_top[2] = 1'b0;
      tick();
      UserRST = 1'b0; bus.o_top[2] = 1'b1;
      for (int j = 0; j < 3; j++) begin tick(); at_mid(); chk("filt_glitch3", 32'(bus.o[2]), 32'h0); end
      bus.o_top[2] = 1'b0;
      for (int j = 0; j < 2; j++) begin tick(); at_mid(); chk("filt_glitch_end", 32'(bus.o[2]), 32'h0); end
      bus.o_top[2] = 1'b1;
      for (int j = 1; j <= 4; j++) begin tick(); at_mid(); chk("filt_rise", 32'(bus.o[2]), 32'(j == 4)); end
      bus.o_top[2] = 1'b0;
      for (int j = 0; j < 3; j++) begin tick(); at_mid(); chk("filt_hold", 32'(bus.o[2]), 32'h1); end
      // Reset in the middle of a count discards it.
      UserRST = 1'b1;
      tick();
      UserRST = 1'b0; bus.o_top[2] = 1'b1;
      tick();
      tick();
      UserRST = 1'b1;
      tick();
      at_mid();
      chk("rst_mid_f", 32'(bus.o[2]), 32'h0);
      UserRST = 1'b0;
      for (int j = 1; j <= 4; j++) begin tick(); at_mid(); chk("rst_mid_rise", 32'(bus.o[2]), 32'(j == 4)); end
`else
      // Synchroniser latency: comb mode immediate, Q and registered mode after three edges.
      cfg[0 +: 6] = 6'b000000;
      cfg[6 +: 6] = 6'b010000;
      UserRST = 1'b1; bus.o_top = '0;
      tick();
      tick();
      UserRST = 1'b0;
      tick(); tick(); tick();
      bus.o_top = '1;
      #1 chk("sync_comb_o0", 32'(bus.o[0]), 32'h1);
      for (int j = 1; j <= 3; j++) begin
         tick();
         at_mid();
         chk("sync_q_lat", 32'(bus.q[1]), 32'(j == 3));
         chk("sync_o_lat", 32'(bus.o[1]), 32'(j == 3));
      end
`endif

      // Each channel a different input mode, identical pad stimulus.
      for (int k = 0; k < NUM_CH; k++) cfg[6*k +: 6] = {2'(k), 4'b0000};
      v = 1'b0;
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(2) == 0) v = ~v;
         bus.o_top = {NUM_CH{v}};
         tick();
         at_mid();
         chk("q_equal", 32'((bus.q == '0) || (bus.q == '1)), 32'h1);
         chk("o3_off",  32'(bus.o[3]), 32'h0);
      end

      // Randomized run: random config, fabric inputs, run-biased pad and occasional resets.
      for (int n = 0; n < 1500; n++) begin
         if (n % 64 == 0) cfg = (NUM_CH*6)'($urandom);
         bus.i   = NUM_CH'($urandom);
         bus.t   = NUM_CH'($urandom);
         for (int k = 0; k < NUM_CH; k++)
            if ($urandom_range(3) == 0) bus.o_top[k] = ~bus.o_top[k];
         UserRST = ($urandom_range(49) == 0);
         tick();
      end
      UserRST = 1'b0;
      tick();
      at_mid();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
